// File: rtl/jk_sequence_driver.sv
// rtl/jk_sequence_driver.sv - serialises a target word into J/K commands for a downstream JK flop and checks its q feedback
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   in_valid    frame word valid
//   in_ready    frame can be accepted (IDLE only)
//   in_data     target pattern, bit 0 driven first
//   j, k        excitation commands to the downstream flop
//   q_fb        q of the downstream flop (same clk/reset)
//   busy        high while a frame is in DRIVE or CHECK
//   done        one-cycle pulse in the first IDLE cycle after a frame
//   mismatch    sticky feedback error for the last/current frame
//   change_cnt  number of non-hold commands in the last/current frame
//
// Optional feature: define JK_DRIVER_TOGGLE_EN to issue every state change
// as a toggle (j=1,k=1) instead of explicit set/reset.

module jk_sequence_driver #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CW-1:0]    change_cnt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] data;
    logic [IW-1:0]    idx;
    logic             shadow;

    logic target;
    logic change;
    logic last_bit;
    logic fb_check;
    logic fb_err;

    assign target   = data[idx];
    assign last_bit = (idx == IW'(WIDTH - 1));
    assign change   = (state == S_DRIVE) && (target != shadow);

    // shadow already holds the bit commanded in the previous cycle, which is
    // exactly what the flop's q should show now; this makes the one-cycle
    // pipelined feedback check a plain compare against shadow.
    assign fb_check = ((state == S_DRIVE) && (idx != '0)) || (state == S_CHECK);
    assign fb_err   = fb_check && (q_fb != shadow);

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        j        = 1'b0;
        k        = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (change) begin
`ifdef JK_DRIVER_TOGGLE_EN
                    j = 1'b1;
                    k = 1'b1;
`else
                    j = target;
                    k = ~target;
`endif
                end
                if (last_bit) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            data       <= '0;
            idx        <= '0;
            shadow     <= 1'b0;
            done       <= 1'b0;
            mismatch   <= 1'b0;
            change_cnt <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == S_CHECK);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data       <= in_data;
                        idx        <= '0;
                        mismatch   <= 1'b0;
                        change_cnt <= '0;
                    end
                end
                S_DRIVE: begin
                    shadow <= target;
                    idx    <= last_bit ? '0 : idx + 1'b1;
                    if (change) begin
                        change_cnt <= change_cnt + 1'b1;
                    end
                    if (fb_err) begin
                        mismatch <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (fb_err) begin
                        mismatch <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_sequence_driver.sv
// tb/tb_jk_sequence_driver.sv - self-checking bench for jk_sequence_driver

module tb_jk_sequence_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [3:0] change_cnt;

    int checks = 0;
    int errors = 0;

    // downstream JK flop and fault injection
    logic qm;
    logic fault = 1'b0;
    logic noise = 1'b0;
    logic exp_q = 1'b0;

    logic [1:0] obs_jk   [0:7];
    logic       obs_q    [0:7];
    logic       obs_busy [1:10];
    logic       obs_done [1:10];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset) qm <= 1'b0;
        else begin
            case ({j, k})
                2'b10:   qm <= 1'b1;
                2'b01:   qm <= 1'b0;
                2'b11:   qm <= ~qm;
                default: qm <= qm;
            endcase
        end
    end
    assign q_fb = fault ? 1'b0 : qm;

    jk_sequence_driver #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .j(j), .k(k), .q_fb(q_fb), .busy(busy), .done(done),
        .mismatch(mismatch), .change_cnt(change_cnt)
    );

    // Reference: command for each bit depends only on the bit and the previously reached level.
    function automatic logic [15:0] ref_cmds(input logic [7:0] w, input logic s);
        logic [15:0] r;
        logic cur;
        r = '0;
        cur = s;
        for (int i = 0; i < 8; i++) begin
            if (w[i] != cur) begin
`ifdef JK_DRIVER_TOGGLE_EN
                r[2*i +: 2] = 2'b11;
`else
                r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
`endif
            end
            cur = w[i];
        end
        return r;
    endfunction

    // Number of level changes along the sequence s, w[0], ..., w[7].
    function automatic int ref_changes(input logic [7:0] w, input logic s);
        logic [7:0] prev;
        prev = {w[6:0], s};
        return $countones(w ^ prev);
    endfunction

    // Presents w at the current negedge and records ten cycles of outputs;
    // returns at the negedge of the expected done cycle.
    task automatic run_frame(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = (c <= 8) ? noise : 1'b0;
            in_data  = 8'($urandom);
            if (c <= 8) obs_jk[c-1] = {j, k};
            if (c >= 2 && c <= 9) obs_q[c-2] = q_fb;
            obs_busy[c] = busy;
            obs_done[c] = done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if ({j, k} !== 2'b00) begin errors++; $display("FAIL reset_jk got %b want 00", {j, k}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
        checks++; if (change_cnt !== 4'd0) begin errors++; $display("FAIL reset_change_cnt got %0d want 0", change_cnt); end
        exp_q = 1'b0;
    endtask

    task automatic test_a5();
        logic [15:0] exp;
        exp = ref_cmds(8'hA5, exp_q);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL a5_in_ready got %b want 1", in_ready); end
        run_frame(8'hA5);
        for (int i = 0; i < 8; i++) begin
            checks++; if (obs_jk[i] !== exp[2*i +: 2]) begin errors++; $display("FAIL a5_jk[%0d] got %b want %b", i, obs_jk[i], exp[2*i +: 2]); end
            checks++; if (obs_q[i] !== exp_q_bit(8'hA5, i)) begin errors++; $display("FAIL a5_q[%0d] got %b want %b", i, obs_q[i], exp_q_bit(8'hA5, i)); end
        end
        for (int c = 1; c <= 9; c++) begin
            checks++; if ({obs_busy[c], obs_done[c]} !== 2'b10) begin errors++; $display("FAIL a5_busy_done cycle %0d got %b want 10", c, {obs_busy[c], obs_done[c]}); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL a5_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", busy); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL a5_mismatch got %b want 0", mismatch); end
        checks++; if (change_cnt !== 4'(ref_changes(8'hA5, exp_q))) begin errors++; $display("FAIL a5_change_cnt got %0d want %0d", change_cnt, ref_changes(8'hA5, exp_q)); end
        exp_q = 1'b1;
    endtask

    function automatic logic exp_q_bit(input logic [7:0] w, input int i);
        return w[i];
    endfunction

    // Accepts 8'h00 in the done cycle left by test_a5.
    task automatic test_back_to_back();
        logic [15:0] exp;
        exp = ref_cmds(8'h00, exp_q);
        checks++; if ({in_ready, done} !== 2'b11) begin errors++; $display("FAIL b2b_ready_done got %b want 11", {in_ready, done}); end
        run_frame(8'h00);
        for (int i = 0; i < 8; i++) begin
            checks++; if (obs_jk[i] !== exp[2*i +: 2]) begin errors++; $display("FAIL b2b_jk[%0d] got %b want %b", i, obs_jk[i], exp[2*i +: 2]); end
        end
        checks++; if (obs_done[1] !== 1'b0) begin errors++; $display("FAIL b2b_done_cleared got %b want 0", obs_done[1]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL b2b_mismatch got %b want 0", mismatch); end
        checks++; if (change_cnt !== 4'd1) begin errors++; $display("FAIL b2b_change_cnt got %0d want 1", change_cnt); end
        exp_q = 1'b0;
    endtask

    task automatic test_fault();
        logic [15:0] exp;
        exp = ref_cmds(8'hFF, exp_q);
        fault = 1'b1;
        run_frame(8'hFF);
        fault = 1'b0;
        checks++; if (obs_jk[0] !== exp[1:0]) begin errors++; $display("FAIL fault_jk0 got %b want %b", obs_jk[0], exp[1:0]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fault_done got %b want 1", done); end
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL fault_mismatch got %b want 1", mismatch); end
        checks++; if (change_cnt !== 4'd1) begin errors++; $display("FAIL fault_change_cnt got %0d want 1", change_cnt); end
        exp_q = 1'b1;
        @(negedge clk);
        checks++; if ({done, mismatch} !== 2'b01) begin errors++; $display("FAIL fault_sticky got %b want 01", {done, mismatch}); end
    endtask

    task automatic test_abort();
        logic [15:0] exp;
        logic seen_done;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q = 1'b0;
        checks++; if ({j, k} !== 2'b00) begin errors++; $display("FAIL abort_jk got %b want 00", {j, k}); end
        checks++; if ({busy, done, in_ready} !== 3'b001) begin errors++; $display("FAIL abort_state got %b want 001", {busy, done, in_ready}); end
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen_done = seen_done | done | busy;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen_done); end
        exp = ref_cmds(8'h01, exp_q);
        run_frame(8'h01);
        checks++; if (obs_jk[0] !== exp[1:0]) begin errors++; $display("FAIL abort_next_jk0 got %b want %b", obs_jk[0], exp[1:0]); end
        checks++; if ({done, mismatch} !== 2'b10) begin errors++; $display("FAIL abort_next_done got %b want 10", {done, mismatch}); end
        exp_q = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  w;
        logic [15:0] exp;
        logic        f;
        int          gap;
        for (int n = 0; n < 25; n++) begin
            w   = 8'($urandom);
            f   = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            if (gap > 0) begin
                checks++; if ({done, in_ready} !== 2'b01) begin errors++; $display("FAIL rnd%0d_gap got %b want 01", n, {done, in_ready}); end
            end
            exp   = ref_cmds(w, exp_q);
            fault = f;
            noise = ($urandom_range(0, 1) == 1);
            run_frame(w);
            fault = 1'b0;
            noise = 1'b0;
            for (int i = 0; i < 8; i++) begin
                checks++; if (obs_jk[i] !== exp[2*i +: 2]) begin errors++; $display("FAIL rnd%0d_jk[%0d] w=%h got %b want %b", n, i, w, obs_jk[i], exp[2*i +: 2]); end
            end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done got %b want 1", n, done); end
            checks++; if (mismatch !== (f && (w != 8'h00))) begin errors++; $display("FAIL rnd%0d_mismatch w=%h got %b want %b", n, w, mismatch, f && (w != 8'h00)); end
            checks++; if (change_cnt !== 4'(ref_changes(w, exp_q))) begin errors++; $display("FAIL rnd%0d_change_cnt w=%h got %0d want %0d", n, w, change_cnt, ref_changes(w, exp_q)); end
            exp_q = w[7];
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
        test_fault();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
